// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl: ordered reset release for NUM_DOM downstream domains.
// After the master reset, all domains are held in reset for a stretch.
// Domains 0..NUM_DOM-1 are then released one at a time. Each release waits
// for that domain's ready acknowledge and then a stretch gap. A missing
// acknowledge parks the sequencer in FAULT until i_req or i_rst.
module reset_seq_ctrl #(
    parameter int unsigned NUM_DOM  = 3,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned MIN_HOLD = 5,
    parameter int unsigned TIMEOUT  = 64,
    localparam int unsigned DW      = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_req,
    input  logic [CNT_W-1:0]   i_stretch,
    input  logic [NUM_DOM-1:0] i_dom_ack,
    output logic [NUM_DOM-1:0] o_dom_rst,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_timeout,
    output logic [DW-1:0]      o_err_dom
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_ASSERT = 3'd0,
        ST_WAIT   = 3'd1,
        ST_GAP    = 3'd2,
        ST_IDLE   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t             r_state;
    logic [DW-1:0]      r_dom;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_s;
    logic [TW-1:0]      r_tcnt;
    logic [NUM_DOM-1:0] r_dom_rst;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic [DW-1:0]      r_err;

    state_t             w_state;
    logic [DW-1:0]      w_dom;
    logic [CNT_W-1:0]   w_cnt;
    logic [CNT_W-1:0]   w_s;
    logic [TW-1:0]      w_tcnt;
    logic [NUM_DOM-1:0] w_dom_rst;
    logic               w_busy;
    logic               w_done;
    logic               w_timeout;
    logic [DW-1:0]      w_err;

    logic [CNT_W-1:0]   w_s_in;
    logic [CNT_W-1:0]   w_s_cur;
    logic               w_cnt_exp;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [TW-1:0]      w_tcnt_inc;
    logic               w_last;
    logic               w_ack;
    logic [DW-1:0]      w_dom_nxt;

    // Clamped stretch; the first counting edge (count==0) uses the live input
    assign w_s_in     = (i_stretch < CNT_W'(MIN_HOLD)) ? CNT_W'(MIN_HOLD) : i_stretch;
    assign w_s_cur    = (r_cnt == '0) ? w_s_in : r_s;
    assign w_cnt_exp  = ((r_cnt + CNT_W'(1)) == w_s_cur);
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_tcnt_inc = (r_tcnt == '1) ? r_tcnt : r_tcnt + TW'(1);
    assign w_last     = (r_dom == DW'(NUM_DOM - 1));
    assign w_ack      = i_dom_ack[r_dom];
    assign w_dom_nxt  = r_dom + DW'(1);

    // Next-state and next-output logic
    always_comb begin
        w_state   = r_state;
        w_dom     = r_dom;
        w_cnt     = r_cnt;
        w_s       = r_s;
        w_tcnt    = r_tcnt;
        w_dom_rst = r_dom_rst;
        w_done    = 1'b0;
        w_timeout = r_timeout;
        w_err     = r_err;

        if (i_req) begin
            w_state   = ST_ASSERT;
            w_dom     = '0;
            w_cnt     = '0;
            w_tcnt    = '0;
            w_dom_rst = '1;
            w_timeout = 1'b0;
            w_err     = '0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (r_cnt == '0) begin
                        w_s = w_s_in;
                    end
                    if (w_cnt_exp) begin
                        w_dom_rst[0] = 1'b0;
                        w_state      = ST_WAIT;
                        w_dom        = '0;
                        w_cnt        = '0;
                        w_tcnt       = '0;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
                ST_WAIT: begin
                    if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        // Timed-out domain goes back into reset; earlier ones stay out
                        w_state   = ST_FAULT;
                        w_timeout = 1'b1;
                        w_err     = r_dom;
                        for (int i = 0; i < int'(NUM_DOM); i++) begin
                            if (DW'(i) == r_dom) begin
                                w_dom_rst[i] = 1'b1;
                            end
                        end
                    end else if (w_ack) begin
                        w_tcnt = '0;
                        if (w_last) begin
                            w_state = ST_IDLE;
                            w_done  = 1'b1;
                        end else begin
                            w_state = ST_GAP;
                            w_cnt   = '0;
                        end
                    end else begin
                        w_tcnt = w_tcnt_inc;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        w_s = w_s_in;
                    end
                    if (w_cnt_exp) begin
                        for (int i = 0; i < int'(NUM_DOM); i++) begin
                            if (DW'(i) == w_dom_nxt) begin
                                w_dom_rst[i] = 1'b0;
                            end
                        end
                        w_state = ST_WAIT;
                        w_dom   = w_dom_nxt;
                        w_cnt   = '0;
                        w_tcnt  = '0;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
                ST_IDLE: begin
                    w_dom_rst = '0;
                end
                ST_FAULT: begin
                    w_state = ST_FAULT;
                end
                default: begin
                    w_state   = ST_ASSERT;
                    w_dom_rst = '1;
                    w_cnt     = '0;
                end
            endcase
        end

        w_busy = (w_state != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_ASSERT;
            r_dom     <= '0;
            r_cnt     <= '0;
            r_s       <= '0;
            r_tcnt    <= '0;
            r_dom_rst <= '1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_err     <= '0;
        end else begin
            r_state   <= w_state;
            r_dom     <= w_dom;
            r_cnt     <= w_cnt;
            r_s       <= w_s;
            r_tcnt    <= w_tcnt;
            r_dom_rst <= w_dom_rst;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_timeout <= w_timeout;
            r_err     <= w_err;
        end
    end

    assign o_dom_rst = r_dom_rst;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_timeout = r_timeout;
    assign o_err_dom = r_err;

endmodule
